// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, single-byte holding register and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic [1:0]  sync_q;
  logic        line;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        evt_byte_q, evt_byte_d;
  logic        evt_ferr_q, evt_ferr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        evt_perr_q, evt_perr_d;
  logic        parity_err_q, parity_err_d;
`endif

  assign line = sync_q[1];

  // Receive FSM; events are registered at the stop sample and applied one edge later.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    evt_byte_d = 1'b0;
    evt_ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    evt_perr_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!line) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          state_d = line ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          par_bad_d = line ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (line) begin
`ifdef UART_RX_PARITY_EN
            evt_byte_d = !par_bad_q;
            evt_perr_d = par_bad_q;
`else
            evt_byte_d = 1'b1;
`endif
          end else begin
            evt_ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a same-cycle rd_en consumes first, so a load then never overruns.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (rd_en) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (evt_byte_q) begin
      if (rx_valid_q && !rd_en) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
    if (evt_ferr_q) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (evt_perr_q) parity_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      evt_byte_q  <= 1'b0;
      evt_ferr_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      evt_perr_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], serial_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      evt_byte_q  <= evt_byte_d;
      evt_ferr_q  <= evt_ferr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      evt_perr_q   <= evt_perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
  assign busy      = (state_q != StIdle);

endmodule
